fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly downstream of the next-PC 2:1 mux (PC+4 vs branch/jump target).
- Holds the program counter and issues one instruction-memory request per PC.
- Buffers the returned word and presents it to the IF/ID boundary with a valid/ready handshake.
- Exports pc_plus4 back to the mux's input 0, closing the next-PC loop.

Parameters:
WIDTH, 32, data/address width of PC and instruction word
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  single system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
next_pc_in  input  WIDTH  selected next PC, from next-PC mux output
redirect  input  1  taken branch/jump this cycle; next_pc_in holds the target
pc_plus4  output  WIDTH  pc_out + 4, combinational; feeds mux input 0
imem_req  output  1  instruction-memory request strobe
imem_addr  output  WIDTH  request address
imem_ack  input  1  memory returns data this cycle
imem_rdata  input  WIDTH  instruction word, valid with imem_ack
instr_valid  output  1  instr_out/pc_out hold a fetched instruction
instr_ready  input  1  decode accepts instruction this cycle
instr_out  output  WIDTH  buffered instruction word
pc_out  output  WIDTH  PC of the current/outstanding fetch

Behaviour:
- Reset (synchronous, active-high, overrides everything including an in-flight ack):
  - state=IDLE, pc_out=RESET_PC, instr_valid=0, instr_out=0, imem_req=0, kill=0, pending_pc=0.
- States:
  - IDLE: imem_req=0. Always go to REQ next cycle.
  - REQ: imem_req=1, imem_addr=pc_out, held stable until imem_ack.
  - HOLD: imem_req=0, instr_valid=1, instr_out/pc_out stable.
- REQ, no ack, redirect=1: latch pending_pc<=next_pc_in, set kill=1. Address is not changed mid-request. A later redirect overwrites pending_pc.
- REQ, ack, kill=0, redirect=0: instr_out<=imem_rdata, go to HOLD.
- REQ, ack, and (kill=1 or redirect=1): discard data.
  - pc_out <= (redirect ? next_pc_in : pending_pc); redirect in the same cycle wins.
  - Clear kill; stay in REQ, issuing the new address next cycle.
- HOLD, redirect=1: flush (instr_valid<=0), pc_out<=next_pc_in, go to REQ. Redirect beats instr_ready; the word is not delivered.
- HOLD, instr_ready=1, redirect=0: transfer completes. pc_out<=next_pc_in (mux selects pc_plus4 when no branch), go to REQ.
- HOLD, instr_ready=0: hold all outputs.
- Latency: first instr_valid no earlier than cycle 2 after reset release plus memory latency. Back-to-back throughput is 1 instruction per 2 cycles with a 1-cycle memory.
- Arithmetic: pc_plus4 = pc_out + 4 modulo 2^WIDTH; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- imem_ack outside REQ is ignored.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined:
  - Adds output align_err (1 bit, reset 0).
  - If pc_out[1:0] != 0 on entering REQ, no request is issued: align_err<=1, enter sticky ERR state (imem_req=0, instr_valid=0) until reset.
- Undefined:
  - No align_err port.
  - imem_addr[1:0] forced to 2'b00; pc_out low bits carried unchanged.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, REQ, HOLD, ERR}
  - PC_STEP=4
  - NOP_WORD=32'h0000_0000 (reset value of instr_out)
- One natural sub-module, pc_reg: WIDTH-bit register with synchronous reset to RESET_PC and a load enable. The FSM, kill/pending_pc and instruction buffer stay in fetch_unit.
- Next-PC selection remains in the existing mux, instantiated by the parent.

Test Plan:
- Reset, then 1-cycle ack memory returning 0x2000_0000+addr, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; instr_out 0x2000_0000,0x2000_0004,0x2000_0008.
- HOLD with instr_ready=0 for 5 cycles -> instr_valid, instr_out and pc_out constant; no new imem_req.
- Redirect to 0x100 while REQ outstanding, ack 3 cycles later -> that word discarded, instr_valid stays 0, next imem_addr=0x100.
- Redirect to 0x40 in HOLD with instr_ready=1 -> no transfer, instr_valid=0 next cycle, next imem_addr=0x40.
- reset asserted in the same cycle as imem_ack -> pc_out=RESET_PC, instr_valid=0, state IDLE.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> align_err=1, imem_req stays 0 until reset; without it, imem_addr=0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold,
    StErr
  } fetch_state_e;

  localparam int unsigned PC_STEP  = 4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return |pc_lo;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus plus the IF/ID valid/ready boundary.
interface fetch_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] instr_out;
  logic [WIDTH-1:0] pc_out;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, pc_out,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, pc_out,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/pc_reg.sv
// Program-counter register: synchronous reset to RESET_PC, loads d when load is high.
module pc_reg #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one imem request per PC, buffered word handed to decode.
// Optional FETCH_ALIGN_CHECK_EN adds align_err and a sticky error state for misaligned PCs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] next_pc_in,
  input  logic             redirect,
  output logic [WIDTH-1:0] pc_plus4,
  fetch_unit_if.master     bus
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic             align_err
`endif
);

  fetch_state_e     state_q;
  logic             req_q;
  logic             valid_q;
  logic             kill_q;
  logic [WIDTH-1:0] pending_pc_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_next;
  logic             pc_load;
  logic             enter_ok;

  // Redirect in the ack cycle wins over a previously latched pending target.
  always_comb begin
    pc_load = 1'b0;
    pc_d    = next_pc_in;
    unique case (state_q)
      StReq: begin
        pc_load = bus.imem_ack && (kill_q || redirect);
        pc_d    = redirect ? next_pc_in : pending_pc_q;
      end
      StHold:  pc_load = redirect || bus.instr_ready;
      default: pc_load = 1'b0;
    endcase
  end

  assign pc_next = pc_load ? pc_d : pc_q;

  pc_reg #(
    .WIDTH   (WIDTH),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .reset(reset),
    .load (pc_load),
    .d    (pc_d),
    .q    (pc_q)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  assign enter_ok      = !pc_misaligned(pc_next[1:0]);
  assign bus.imem_addr = pc_q;
  assign align_err     = (state_q == StErr);
`else
  assign enter_ok      = 1'b1;
  assign bus.imem_addr = {pc_q[WIDTH-1:2], 2'b00};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      kill_q       <= 1'b0;
      pending_pc_q <= '0;
      instr_q      <= WIDTH'(NOP_WORD);
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= enter_ok ? StReq : StErr;
          req_q   <= enter_ok;
        end
        StReq: begin
          if (bus.imem_ack) begin
            if (kill_q || redirect) begin
              kill_q  <= 1'b0;
              state_q <= enter_ok ? StReq : StErr;
              req_q   <= enter_ok;
            end else begin
              instr_q <= bus.imem_rdata;
              valid_q <= 1'b1;
              req_q   <= 1'b0;
              state_q <= StHold;
            end
          end else if (redirect) begin
            // Address stays put; the in-flight word is dropped when it returns.
            pending_pc_q <= next_pc_in;
            kill_q       <= 1'b1;
          end
        end
        StHold: begin
          if (redirect || bus.instr_ready) begin
            valid_q <= 1'b0;
            state_q <= enter_ok ? StReq : StErr;
            req_q   <= enter_ok;
          end
        end
        StErr: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_plus4        = pc_q + WIDTH'(PC_STEP);
  assign bus.imem_req    = req_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory returns 0x2000_0000 + address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic        auto_ack = 1'b1;
  logic        man_ack = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] next_pc_in;
  logic [31:0] pc_plus4;
  int          n_checks = 0;
  int          n_errors = 0;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        align_err;
`endif

  fetch_unit_if #(.WIDTH(32)) bus ();

  fetch_unit #(
    .WIDTH   (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .next_pc_in(next_pc_in),
    .redirect  (redirect),
    .pc_plus4  (pc_plus4),
    .bus       (bus)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .align_err (align_err)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for the next-PC mux and a simple instruction memory.
  assign next_pc_in     = redirect ? target : pc_plus4;
  assign bus.imem_ack   = auto_ack ? bus.imem_req : man_ack;
  assign bus.imem_rdata = 32'h2000_0000 + bus.imem_addr;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    bus.instr_ready = 1'b1;

    cycle();
    check_eq("rst_pc", bus.pc_out, 32'h0);
    check_eq("rst_valid", 32'(bus.instr_valid), 32'h0);
    check_eq("rst_req", 32'(bus.imem_req), 32'h0);
    check_eq("rst_instr", bus.instr_out, 32'h0);
    check_eq("rst_plus4", pc_plus4, 32'h4);
    reset = 1'b0;

    // Streaming with a 1-cycle memory and decode always ready.
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("seq_req", 32'(bus.imem_req), 32'h1);
      check_eq("seq_addr", bus.imem_addr, 32'(4 * k));
      check_eq("seq_valid0", 32'(bus.instr_valid), 32'h0);
      cycle();
      check_eq("seq_valid1", 32'(bus.instr_valid), 32'h1);
      check_eq("seq_instr", bus.instr_out, 32'h2000_0000 + 32'(4 * k));
      check_eq("seq_pc", bus.pc_out, 32'(4 * k));
    end

    // Decode stalls: everything holds, no new request.
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_eq("stall_valid", 32'(bus.instr_valid), 32'h1);
      check_eq("stall_instr", bus.instr_out, 32'h2000_0008);
      check_eq("stall_pc", bus.pc_out, 32'h8);
      check_eq("stall_req", 32'(bus.imem_req), 32'h0);
    end

    // Redirect while a request is outstanding; the late word must be dropped.
    auto_ack = 1'b0;
    bus.instr_ready = 1'b1;
    cycle();
    check_eq("kill_addr0", bus.imem_addr, 32'hC);
    redirect = 1'b1;
    target   = 32'h100;
    cycle();
    redirect = 1'b0;
    check_eq("kill_addr_held", bus.imem_addr, 32'hC);
    check_eq("kill_req_held", 32'(bus.imem_req), 32'h1);
    cycle();
    cycle();
    man_ack = 1'b1;
    cycle();
    check_eq("kill_valid", 32'(bus.instr_valid), 32'h0);
    check_eq("kill_req", 32'(bus.imem_req), 32'h1);
    check_eq("kill_addr_new", bus.imem_addr, 32'h100);

    // Accept the 0x100 word, then redirect in HOLD with decode ready.
    cycle();
    man_ack = 1'b0;
    check_eq("hold_instr", bus.instr_out, 32'h2000_0100);
    redirect = 1'b1;
    target   = 32'h40;
    cycle();
    redirect = 1'b0;
    check_eq("flush_valid", 32'(bus.instr_valid), 32'h0);
    check_eq("flush_addr", bus.imem_addr, 32'h40);
    check_eq("flush_req", 32'(bus.imem_req), 32'h1);

    // Reset coincident with an ack; ack left high in IDLE is ignored.
    man_ack = 1'b1;
    reset   = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("rack_pc", bus.pc_out, 32'h0);
    check_eq("rack_valid", 32'(bus.instr_valid), 32'h0);
    check_eq("rack_req", 32'(bus.imem_req), 32'h0);
    check_eq("rack_instr", bus.instr_out, 32'h0);
    cycle();
    check_eq("idle_ack_req", 32'(bus.imem_req), 32'h1);
    check_eq("idle_ack_valid", 32'(bus.instr_valid), 32'h0);
    cycle();
    man_ack = 1'b0;
    check_eq("post_rst_instr", bus.instr_out, 32'h2000_0000);

    // PC at top of address space: pc_plus4 wraps to zero.
    redirect = 1'b1;
    target   = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    check_eq("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    check_eq("wrap_plus4", pc_plus4, 32'h0);
    man_ack = 1'b1;
    cycle();
    man_ack = 1'b0;
    check_eq("wrap_instr", bus.instr_out, 32'h1FFF_FFFC);

    // Misaligned redirect target.
    redirect = 1'b1;
    target   = 32'h102;
    cycle();
    redirect = 1'b0;
    check_eq("mis_pc", bus.pc_out, 32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("mis_err", 32'(align_err), 32'h1);
    check_eq("mis_valid", 32'(bus.instr_valid), 32'h0);
    for (int k = 0; k < 3; k++) begin
      check_eq("mis_req", 32'(bus.imem_req), 32'h0);
      cycle();
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("mis_err_clr", 32'(align_err), 32'h0);
`else
    check_eq("mis_req", 32'(bus.imem_req), 32'h1);
    check_eq("mis_addr", bus.imem_addr, 32'h100);
    man_ack = 1'b1;
    cycle();
    man_ack = 1'b0;
    check_eq("mis_instr", bus.instr_out, 32'h2000_0100);
    check_eq("mis_pc_hold", bus.pc_out, 32'h102);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
